// File: rtl/rtl_settings_pkg.sv
// Shared settings for the traffic generator: bus geometry, CSR field layout,
// test/address mode encodings and the transmitter command packet.
package rtl_settings_pkg;

    localparam int DATA_B_W    = 4;
    localparam int ADDR_B_W    = (DATA_B_W > 1) ? $clog2(DATA_B_W) : 1;
    localparam int AMM_ADDR_W  = 30;
    localparam int AMM_BURST_W = 11;

    typedef enum logic {
        BYTE_ADDR = 1'b0,
        WORD_ADDR = 1'b1
    } addr_type_t;

    localparam addr_type_t ADDR_TYPE = BYTE_ADDR;

    typedef enum logic [1:0] {
        WRITE_ONLY      = 2'd0,
        READ_ONLY       = 2'd1,
        WRITE_AND_CHECK = 2'd2
    } test_mode_t;

    typedef enum logic [1:0] {
        FIX_ADDR = 2'd0,
        RUN_ADDR = 2'd1,
        RND_ADDR = 2'd2
    } addr_mode_t;

    // CSR test parameter word indices and field positions
    localparam int CSR_ITER_IDX      = 0;
    localparam int CSR_CFG_IDX       = 1;
    localparam int CSR_BASE_IDX      = 3;
    localparam int CSR_TEST_MODE_LSB = 16;
    localparam int CSR_ADDR_MODE_LSB = 20;

    // x^32 + x^22 + x^2 + x + 1 in right-shifting Galois form
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    typedef struct packed {
        logic                  pkt_type;
        logic [AMM_ADDR_W-1:0] word_addr;
        logic [ADDR_B_W-1:0]   start_offset;
        logic [ADDR_B_W-1:0]   end_offset;
        logic [ADDR_B_W:0]     low_burst_bits;
    } trans_pkt_t;

    function automatic logic [31:0] lfsr_step(input logic [31:0] state);
        logic [31:0] nxt;
        if (state[0]) begin
            nxt = (state >> 1) ^ LFSR_TAPS;
        end else begin
            nxt = state >> 1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/addr_gen.sv
// Address generator: holds the current byte address and LFSR, and derives the
// packet fields for both the current and the next address.
module addr_gen
    import rtl_settings_pkg::*;
#(
    parameter logic [31:0] LFSR_SEED = 32'h0000_0001
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_load,
    input  logic                   i_advance,
    input  logic [31:0]            i_base_addr,
    input  logic [AMM_BURST_W-2:0] i_burstcount,
    input  addr_mode_t             i_addr_mode,
    input  logic                   i_pkt_type,
    output trans_pkt_t             o_cur_pkt,
    output trans_pkt_t             o_next_pkt
);

    logic [31:0]            r_addr;
    logic [31:0]            r_lfsr;
    logic [AMM_BURST_W-2:0] r_burst;
    addr_mode_t             r_addr_mode;
    logic [31:0]            w_lfsr_next;
    logic [31:0]            w_next_addr;

    function automatic trans_pkt_t build_pkt(input logic [31:0] addr,
                                             input logic [AMM_BURST_W-2:0] bc,
                                             input logic pkt_type);
        trans_pkt_t  pkt;
        logic [31:0] last_byte;
        pkt          = '0;
        pkt.pkt_type = pkt_type;
        last_byte    = addr + 32'(bc);
        if (ADDR_TYPE == BYTE_ADDR) begin
            pkt.word_addr      = AMM_ADDR_W'(addr >> ADDR_B_W);
            pkt.start_offset   = addr[ADDR_B_W-1:0];
            pkt.end_offset     = last_byte[ADDR_B_W-1:0];
            // kept one bit wider so a burst crossing a word boundary is visible
            pkt.low_burst_bits = {1'b0, addr[ADDR_B_W-1:0]} + {1'b0, bc[ADDR_B_W-1:0]};
        end else begin
            pkt.word_addr      = addr[AMM_ADDR_W-1:0];
        end
        return pkt;
    endfunction

    // Next-address selection and packet field arithmetic
    always_comb begin
        w_lfsr_next = lfsr_step(r_lfsr);
        case (r_addr_mode)
            FIX_ADDR: w_next_addr = r_addr;
            RUN_ADDR: w_next_addr = r_addr + 32'(r_burst) + 32'd1;
            RND_ADDR: w_next_addr = w_lfsr_next;
            default:  w_next_addr = r_addr;
        endcase
        o_cur_pkt  = build_pkt(r_addr, r_burst, i_pkt_type);
        o_next_pkt = build_pkt(w_next_addr, r_burst, i_pkt_type);
    end

    // Address, LFSR and latched geometry registers
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_addr      <= 32'd0;
            r_lfsr      <= LFSR_SEED;
            r_burst     <= '0;
            r_addr_mode <= FIX_ADDR;
        end else if (i_load) begin
            r_addr      <= i_base_addr;
            r_lfsr      <= LFSR_SEED;
            r_burst     <= i_burstcount;
            r_addr_mode <= i_addr_mode;
        end else if (i_advance) begin
            r_addr      <= w_next_addr;
            r_lfsr      <= w_lfsr_next;
        end
    end

endmodule

// File: rtl/test_sequencer.sv
// Test sequencer: walks the CSR-programmed test, issuing write/read packets to
// the transmitter command port and reporting completion or error.
module test_sequencer
    import rtl_settings_pkg::*;
#(
    parameter logic [31:0] LFSR_SEED = 32'h0000_0001
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_test_i,
    input  logic [3:0][31:0] test_param_reg_i,
    input  logic             error_check_i,
    input  logic             cmd_accept_ready_i,
    input  logic             trans_block_busy_i,
    output logic             op_valid_o,
    output trans_pkt_t       op_pkt_o,
    output logic             busy_o,
    output logic             test_done_o,
    output logic             test_error_o,
    output logic [31:0]      op_cnt_o
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOAD     = 3'd1;
    localparam logic [2:0] S_ISSUE_WR = 3'd2;
    localparam logic [2:0] S_ISSUE_RD = 3'd3;
    localparam logic [2:0] S_DRAIN    = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    logic [2:0]             r_state;
    logic [31:0]            r_iter_cnt;
    test_mode_t             r_test_mode;
    logic                   r_op_valid;
    trans_pkt_t             r_op_pkt;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_error;
    logic [31:0]            r_op_cnt;

    logic                   w_start;
    logic                   w_accept;
    logic                   w_iter_end;
    logic                   w_last;
    logic                   w_rd_first;
    test_mode_t             w_param_mode;
    addr_mode_t             w_param_amode;
    logic [AMM_BURST_W-2:0] w_param_burst;
    trans_pkt_t             w_cur_pkt;
    trans_pkt_t             w_next_pkt;
    logic                   w_unused_bits;

    assign w_unused_bits = ^{test_param_reg_i[2], test_param_reg_i[CSR_CFG_IDX][31:22],
                             test_param_reg_i[CSR_CFG_IDX][19:18],
                             test_param_reg_i[CSR_CFG_IDX][15:AMM_BURST_W-1]};

    // Parameter decode and handshake/iteration qualifiers
    always_comb begin
        w_param_mode  = test_mode_t'(test_param_reg_i[CSR_CFG_IDX][CSR_TEST_MODE_LSB +: 2]);
        w_param_amode = addr_mode_t'(test_param_reg_i[CSR_CFG_IDX][CSR_ADDR_MODE_LSB +: 2]);
        w_param_burst = test_param_reg_i[CSR_CFG_IDX][AMM_BURST_W-2:0];
        w_start       = (r_state == S_IDLE) && start_test_i;
        w_accept      = r_op_valid && cmd_accept_ready_i;
        if (r_state == S_ISSUE_RD) begin
            w_iter_end = w_accept;
        end else if (r_state == S_ISSUE_WR) begin
            w_iter_end = w_accept && (r_test_mode != WRITE_AND_CHECK);
        end else begin
            w_iter_end = 1'b0;
        end
        w_last     = w_iter_end && (r_iter_cnt == 32'd1);
        w_rd_first = (r_test_mode == READ_ONLY);
    end

    addr_gen #(
        .LFSR_SEED (LFSR_SEED)
    ) u_addr_gen (
        .i_clk        (clk_i),
        .i_rst_n      (rst_i),
        .i_load       (w_start),
        .i_advance    (w_iter_end),
        .i_base_addr  (test_param_reg_i[CSR_BASE_IDX]),
        .i_burstcount (w_param_burst),
        .i_addr_mode  (w_param_amode),
        .i_pkt_type   (w_rd_first),
        .o_cur_pkt    (w_cur_pkt),
        .o_next_pkt   (w_next_pkt)
    );

    // Sequencer FSM, counters and registered outputs
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state     <= S_IDLE;
            r_iter_cnt  <= 32'd0;
            r_test_mode <= WRITE_ONLY;
            r_op_valid  <= 1'b0;
            r_op_pkt    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_op_cnt    <= 32'd0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_op_cnt <= r_op_cnt + 32'd1;
            end
            if ((r_state != S_IDLE) && error_check_i) begin
                // abort without draining; an accept on this edge still counts
                r_error    <= 1'b1;
                r_op_valid <= 1'b0;
                if (r_state == S_DONE) begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end else begin
                    r_state <= S_DONE;
                end
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start_test_i) begin
                            r_test_mode <= w_param_mode;
                            r_iter_cnt  <= test_param_reg_i[CSR_ITER_IDX];
                            r_op_cnt    <= 32'd0;
                            r_error     <= 1'b0;
                            r_busy      <= 1'b1;
                            r_state     <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        if (r_iter_cnt == 32'd0) begin
                            r_state <= S_DONE;
                        end else begin
                            r_op_pkt   <= w_cur_pkt;
                            r_op_valid <= 1'b1;
                            r_state    <= w_rd_first ? S_ISSUE_RD : S_ISSUE_WR;
                        end
                    end
                    S_ISSUE_WR, S_ISSUE_RD: begin
                        if (w_accept && !w_iter_end) begin
                            r_op_pkt.pkt_type <= 1'b1;
                            r_state           <= S_ISSUE_RD;
                        end else if (w_iter_end) begin
                            r_iter_cnt <= r_iter_cnt - 32'd1;
                            if (w_last) begin
                                r_op_valid <= 1'b0;
                                r_state    <= S_DRAIN;
                            end else begin
                                r_op_pkt <= w_next_pkt;
                                r_state  <= w_rd_first ? S_ISSUE_RD : S_ISSUE_WR;
                            end
                        end
                    end
                    S_DRAIN: begin
                        if (!trans_block_busy_i && cmd_accept_ready_i) begin
                            r_state <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_op_valid <= 1'b0;
                        r_busy     <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign op_valid_o   = r_op_valid;
    assign op_pkt_o     = r_op_pkt;
    assign busy_o       = r_busy;
    assign test_done_o  = r_done;
    assign test_error_o = r_error;
    assign op_cnt_o     = r_op_cnt;

endmodule
